// File: rtl/w_bit_n_demux_reg.sv
// w_bit_n_demux_reg
//   W-bit 1:N registered demultiplexer. One input stream is steered to one of
//   N output channels by sel. Each channel owns a one-entry output register
//   with a valid/ready handshake. A word whose sel is not a real channel
//   (sel >= N) is accepted, discarded and flagged on drop for one cycle.
//
//   Optional feature macro: WBN_DEMUX_CNT_EN
//     When defined, adds port cnt: one 8-bit wrapping counter per channel
//     counting output transfers.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   in_data    in   W      input word
//   in_valid   in   1      input word present
//   in_ready   out  1      input accepted this cycle (combinational)
//   sel        in   m      destination channel
//   out_data   out  N*W    channel i on bits [i*W +: W]
//   out_valid  out  N      channel i register full
//   out_ready  in   N      consumer i accepts this cycle
//   drop       out  1      one-cycle pulse: word discarded (sel >= N)
//   cnt        out  N*8    (WBN_DEMUX_CNT_EN only) per-channel transfer count

module w_bit_n_demux_reg #(
    parameter int unsigned N = 4,
    parameter int unsigned m = 2,
    parameter int unsigned W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [m-1:0]     sel,
    output logic [N*W-1:0]   out_data,
    output logic [N-1:0]     out_valid,
    input  logic [N-1:0]     out_ready,
    output logic             drop
`ifdef WBN_DEMUX_CNT_EN
    ,
    output logic [N*8-1:0]   cnt
`endif
);

    localparam int unsigned CW = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           st_q [N];
    logic [N*W-1:0]   data_q;
    logic             drop_q;

    logic [N-1:0]     sel_hit;
    logic             sel_ok;
    logic             in_xfer;
    logic [N-1:0]     load;
    logic [N-1:0]     drain;

    // One-hot decode of sel; sel values at or above N hit no channel.
    always_comb begin
        sel_hit = '0;
        for (int i = 0; i < int'(N); i++) begin
            sel_hit[i] = (sel == m'(i));
        end
    end

    // Channel state is the valid flag seen by the consumer.
    always_comb begin
        out_valid = '0;
        for (int i = 0; i < int'(N); i++) begin
            out_valid[i] = (st_q[i] == FULL);
        end
    end

    assign sel_ok = |sel_hit;

    // Ready depends only on the addressed channel's state and its consumer;
    // an invalid destination always accepts so the word can be dropped.
    assign in_ready = sel_ok ? |(sel_hit & (~out_valid | out_ready)) : 1'b1;
    assign in_xfer  = in_valid & in_ready;
    assign load     = {N{in_xfer}} & sel_hit;
    assign drain    = out_valid & out_ready;

    assign out_data = data_q;
    assign drop     = drop_q;

    // Per-channel EMPTY/FULL FSMs and data registers. A load wins over a
    // simultaneous drain so a full channel sustains one word per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N); i++) begin
                st_q[i] <= EMPTY;
            end
            data_q <= '0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= in_xfer & ~sel_ok;
            for (int i = 0; i < int'(N); i++) begin
                case (st_q[i])
                    EMPTY: begin
                        if (load[i]) begin
                            st_q[i] <= FULL;
                        end
                    end
                    FULL: begin
                        if (!load[i] && drain[i]) begin
                            st_q[i] <= EMPTY;
                        end
                    end
                    default: st_q[i] <= EMPTY;
                endcase
                if (load[i]) begin
                    data_q[i*W +: W] <= in_data;
                end
            end
        end
    end

`ifdef WBN_DEMUX_CNT_EN
    logic [N*CW-1:0] cnt_q;

    // Output-transfer counters, wrapping naturally at 2**CW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                if (drain[i]) begin
                    cnt_q[i*CW +: CW] <= cnt_q[i*CW +: CW] + CW'(1);
                end
            end
        end
    end

    assign cnt = cnt_q;
`endif

endmodule
